// File: rtl/video_frame_monitor.sv
// video_frame_monitor: passive checker on the video output stream.
// Measures active pixels per line, active lines per frame and sync
// protocol violations, and publishes a status word once per frame.
// Define FRAME_CRC_EN to add a per-frame CRC-32 of the active pixels.
module video_frame_monitor #(
    parameter int IMG_HDISP  = 1280,
    parameter int IMG_VDISP  = 720,
    parameter int DATA_WIDTH = 24,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  video_clk,
    input  logic                  rst,
    input  logic                  video_vsync,
    input  logic                  video_hsync,
    input  logic                  video_de,
    input  logic [DATA_WIDTH-1:0] video_data,
    output logic                  frame_done,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic                  h_err,
    output logic                  v_err,
    output logic                  sync_err,
    output logic [15:0]           last_lines,
    output logic [31:0]           frame_crc
);
    localparam int PIX_W = $clog2(IMG_HDISP) + 2;

    typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;
    state_t state, state_nxt;

    logic             s1_vsync, s1_hsync, s1_de;
    logic             s2_vsync, s2_de;
    logic             vs_rise, de_fall, line_close;
    logic [PIX_W-1:0] pix_cnt;
    logic [PIX_W:0]   line_len;
    logic [15:0]      line_cnt;
    logic             h_acc, s_acc;

    // Input stage: one register for everything, a second for edge detection.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            s1_vsync <= 1'b0;
            s1_hsync <= 1'b0;
            s1_de    <= 1'b0;
            s2_vsync <= 1'b0;
            s2_de    <= 1'b0;
        end else begin
            s1_vsync <= video_vsync;
            s1_hsync <= video_hsync;
            s1_de    <= video_de;
            s2_vsync <= s1_vsync;
            s2_de    <= s1_de;
        end
    end

    assign vs_rise    = s1_vsync & ~s2_vsync;
    assign de_fall    = ~s1_de & s2_de;
    // A line still open when the frame closes is ended here, including
    // the pixel present on this cycle.
    assign line_close = de_fall | (vs_rise & s1_de);
    assign line_len   = {1'b0, pix_cnt} + {{PIX_W{1'b0}}, s1_de};

    // State register.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: IDLE waits out the partial frame after reset.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vs_rise) state_nxt = ACTIVE;
            ACTIVE:  if (vs_rise) state_nxt = REPORT;
            REPORT:  state_nxt = ACTIVE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-frame accumulators: pixel/line counters and sticky error flags.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            h_acc    <= 1'b0;
            s_acc    <= 1'b0;
        end else begin
            case (state)
                ACTIVE: begin
                    if (s1_de && pix_cnt != '1) pix_cnt <= pix_cnt + PIX_W'(1);
                    if (line_close) begin
                        if (line_cnt != '1) line_cnt <= line_cnt + 16'd1;
                        if (line_len != (PIX_W+1)'(IMG_HDISP)) h_acc <= 1'b1;
                        pix_cnt <= '0;
                    end
                    if (s1_de && (s1_vsync || s1_hsync)) s_acc <= 1'b1;
                end
                REPORT: begin
                    pix_cnt  <= '0;
                    line_cnt <= '0;
                    h_acc    <= 1'b0;
                    s_acc    <= 1'b0;
                end
                default: begin
                    if (vs_rise) begin
                        pix_cnt  <= '0;
                        line_cnt <= '0;
                        h_acc    <= 1'b0;
                        s_acc    <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Status word: latched in REPORT and held until the next frame closes.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            h_err      <= 1'b0;
            v_err      <= 1'b0;
            sync_err   <= 1'b0;
            last_lines <= '0;
        end else begin
            frame_done <= (state == REPORT);
            if (state == REPORT) begin
                frame_cnt  <= frame_cnt + CNT_WIDTH'(1);
                h_err      <= h_acc;
                v_err      <= (line_cnt != 16'(IMG_VDISP));
                sync_err   <= s_acc;
                last_lines <= line_cnt;
            end
        end
    end

`ifdef FRAME_CRC_EN
    logic [DATA_WIDTH-1:0] s1_data;
    logic [31:0]           crc_acc;

    // CRC-32 (0x04C11DB7), non-reflected, whole pixel folded MSB first.
    function automatic logic [31:0] crc_fold(input logic [31:0] c, input logic [DATA_WIDTH-1:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = DATA_WIDTH-1; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
        end
        return r;
    endfunction

    // Pixel data register, aligned with s1_de.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) s1_data <= '0;
        else     s1_data <= video_data;
    end

    // Running CRC over the frame's active pixels; reported in REPORT.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            crc_acc   <= 32'hFFFFFFFF;
            frame_crc <= 32'h0;
        end else begin
            case (state)
                ACTIVE:  if (s1_de) crc_acc <= crc_fold(crc_acc, s1_data);
                REPORT: begin
                    frame_crc <= crc_acc;
                    crc_acc   <= 32'hFFFFFFFF;
                end
                default: if (vs_rise) crc_acc <= 32'hFFFFFFFF;
            endcase
        end
    end
`else
    logic data_unused;
    assign data_unused = ^video_data;
    assign frame_crc   = 32'h0;
`endif

endmodule

// File: tb/tb_video_frame_monitor.sv
// tb_video_frame_monitor: directed and randomized frames against a
// frame-level model (line lengths, line count, injected sync faults, CRC).
module tb_video_frame_monitor;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int DW = 24;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          vs, hs, de;
    logic [DW-1:0] data;
    logic          frame_done;
    logic [CW-1:0] frame_cnt;
    logic          h_err, v_err, sync_err;
    logic [15:0]   last_lines;
    logic [31:0]   frame_crc;

    video_frame_monitor #(.IMG_HDISP(H), .IMG_VDISP(V), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .video_clk(clk), .rst(rst), .video_vsync(vs), .video_hsync(hs), .video_de(de),
        .video_data(data), .frame_done(frame_done), .frame_cnt(frame_cnt), .h_err(h_err),
        .v_err(v_err), .sync_err(sync_err), .last_lines(last_lines), .frame_crc(frame_crc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // frame model
    int            m_cnt;
    int            m_lines;
    bit            m_h, m_s;
    logic [DW-1:0] m_pix[$];
    int            data_mode;
    bit            flip_next;
    logic [DW-1:0] tail_pix;
    logic [31:0]   crc_a, crc_c;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lines = 0;
        m_h = 1'b0;
        m_s = 1'b0;
        m_pix.delete();
    endtask

    function automatic logic [31:0] exp_crc();
`ifdef FRAME_CRC_EN
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (m_pix[k])
            for (int b = DW-1; b >= 0; b--) begin
                fb = c[31] ^ m_pix[k][b];
                c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
            end
        return c;
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [DW-1:0] next_pix();
        logic [DW-1:0] p;
        p = (data_mode == 0) ? DW'($urandom) : '0;
        if (flip_next) begin
            p[5] = ~p[5];
            flip_next = 1'b0;
        end
        return p;
    endfunction

    task automatic step(input logic v, input logic h, input logic d, input logic [DW-1:0] px);
        vs = v; hs = h; de = d; data = px;
        @(posedge clk); #1;
    endtask

    // hsync pulse, back porch, len pixels, gap idle cycles. open_end leaves
    // the last pixel for the vsync cycle (de held across the vsync edge).
    task automatic send_line(input int len, input int gap, input bit inj, input bit open_end);
        int            inj_at;
        int            npix;
        logic [DW-1:0] p;
        step(0, 1, 0, '0); step(0, 1, 0, '0);
        step(0, 0, 0, '0); step(0, 0, 0, '0);
        npix   = open_end ? len - 1 : len;
        inj_at = inj ? int'($urandom_range(0, npix - 1)) : -1;
        for (int i = 0; i < npix; i++) begin
            p = next_pix();
            m_pix.push_back(p);
            step(0, (i == inj_at), 1, p);
        end
        if (open_end) begin
            tail_pix = next_pix();
            m_pix.push_back(tail_pix);
            m_s = 1'b1;
        end
        for (int i = 0; i < gap; i++) step(0, 0, 0, '0);
        m_lines++;
        if (len != H) m_h = 1'b1;
        if (inj) m_s = 1'b1;
    endtask

    task automatic send_frame(input int n, input int bad_idx, input int bad_len, input int last_gap);
        for (int i = 0; i < n; i++)
            send_line((i == bad_idx) ? bad_len : H, (i == n - 1) ? last_gap : 3, 1'b0, 1'b0);
    endtask

    task automatic chk_status(input logic e_h, input logic e_v, input logic e_s,
                              input logic [15:0] e_l, input logic [31:0] e_crc);
        chk("h_err", h_err, e_h);
        chk("v_err", v_err, e_v);
        chk("sync_err", sync_err, e_s);
        chk("last_lines", last_lines, e_l);
        chk("frame_crc", frame_crc, e_crc);
    endtask

    // Drive a vsync pulse (or two pulses one cycle apart) and watch the
    // status window that follows it.
    task automatic do_vsync(input bit expect_rep, input bit dbl, input bit tail);
        int          ndone = 0;
        int          first_at = 0;
        logic        e_h, e_v, e_s;
        logic [15:0] e_l;
        logic [31:0] e_crc;
        e_h = m_h; e_v = (m_lines != V); e_s = m_s; e_l = 16'(m_lines); e_crc = exp_crc();
        vs = 1'b1; hs = 1'b0; de = tail; data = tail ? tail_pix : '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                ndone++;
                if (ndone == 1 && expect_rep) begin
                    first_at = c;
                    m_cnt++;
                    chk_status(e_h, e_v, e_s, e_l, e_crc);
                    chk("frame_cnt", frame_cnt, m_cnt % (1 << CW));
                end else if (dbl) begin
                    m_cnt++;
                    model_reset();
                    e_h = 1'b0; e_v = (V != 0); e_s = 1'b0; e_l = 16'd0; e_crc = exp_crc();
                    chk_status(e_h, e_v, e_s, e_l, e_crc);
                    chk("frame_cnt_b2b", frame_cnt, m_cnt % (1 << CW));
                end
            end
            @(posedge clk); #1;
            vs = dbl ? (c == 2) : (c == 1);
            de = 1'b0; data = '0;
        end
        chk("done_count", ndone, (expect_rep ? 1 : 0) + (dbl ? 1 : 0));
        if (expect_rep) begin
            chk("done_latency", first_at, 4);
            chk_status(e_h, e_v, e_s, e_l, e_crc);
        end
        chk("frame_cnt_hold", frame_cnt, m_cnt % (1 << CW));
        model_reset();
    endtask

    initial begin
        rst = 1'b1; vs = 0; hs = 0; de = 0; data = '0;
        m_cnt = 0; data_mode = 0; flip_next = 1'b0; tail_pix = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_cnt", frame_cnt, 0);
        chk_status(1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // traffic before the first vsync is ignored
        send_line(5, 3, 1'b1, 1'b0);
        send_line(H, 3, 1'b0, 1'b0);
        do_vsync(1'b0, 1'b0, 1'b0);

        // two clean frames
        send_frame(V, -1, H, 3); do_vsync(1'b1, 1'b0, 1'b0);
        send_frame(V, -1, H, 3); do_vsync(1'b1, 1'b0, 1'b0);

        // short line 2, then clean frame clears h_err
        send_frame(V, 1, H - 1, 3); do_vsync(1'b1, 1'b0, 1'b0);
        send_frame(V, -1, H, 3);    do_vsync(1'b1, 1'b0, 1'b0);

        // five lines
        send_frame(V + 1, -1, H, 3); do_vsync(1'b1, 1'b0, 1'b0);

        // vsync pulses one cycle apart: second frame is empty
        send_frame(V, -1, H, 3); do_vsync(1'b1, 1'b1, 1'b0);

        // de held high across the vsync rising edge
        send_frame(V - 1, -1, H, 3);
        send_line(H, 0, 1'b0, 1'b1);
        do_vsync(1'b1, 1'b0, 1'b1);

        // de falls on the same cycle vsync rises
        send_frame(V, -1, H, 0); do_vsync(1'b1, 1'b0, 1'b0);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            int nl;
            nl = int'($urandom_range(V - 1, V + 1));
            for (int l = 0; l < nl; l++) begin
                int len;
                len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(H - 2, H + 2)) : H;
                send_line(len, (l == nl - 1) ? int'($urandom_range(0, 3)) : 3,
                          ($urandom_range(0, 5) == 0), 1'b0);
            end
            do_vsync(1'b1, 1'b0, 1'b0);
        end

        // constant-zero frames, then one flipped bit
        data_mode = 1;
        send_frame(V, -1, H, 3); do_vsync(1'b1, 1'b0, 1'b0);
        crc_a = frame_crc;
        send_frame(V, -1, H, 3); do_vsync(1'b1, 1'b0, 1'b0);
        send_line(H, 3, 1'b0, 1'b0);
        flip_next = 1'b1;
        send_frame(V - 1, -1, H, 3); do_vsync(1'b1, 1'b0, 1'b0);
        crc_c = frame_crc;
`ifdef FRAME_CRC_EN
        chk("crc_flip_differs", (crc_c != crc_a), 1'b1);
`endif
        data_mode = 0;

        // reset during line 3
        send_line(H, 3, 1'b0, 1'b0);
        send_line(H, 3, 1'b0, 1'b0);
        step(0, 0, 0, '0); step(0, 0, 0, '0);
        step(0, 0, 1, 24'h123456); step(0, 0, 1, 24'h654321);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_done", frame_done, 1'b0);
        chk("midrst_cnt", frame_cnt, 0);
        chk_status(1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; de = 1'b0;
        m_cnt = 0;
        model_reset();
        do_vsync(1'b0, 1'b0, 1'b0);
        send_frame(V, -1, H, 3); do_vsync(1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
